// File: rtl/db_resp_queue_if.sv
// Request/response AXI-Stream bundle for the doorbell responder.
// The slave modport is the responder's view; the master modport is the fabric side.
interface db_resp_queue_if;
  logic        treq_tvalid_in;
  logic        treq_tready_o;
  logic        treq_tlast_in;
  logic [63:0] treq_tdata_in;
  logic [7:0]  treq_tkeep_in;
  logic [31:0] treq_tuser_in;

  logic        tresp_tready_in;
  logic        tresp_tvalid_o;
  logic        tresp_tlast_o;
  logic [63:0] tresp_tdata_o;
  logic [7:0]  tresp_tkeep_o;
  logic [31:0] tresp_tuser_o;

  modport slave (
    input  treq_tvalid_in,
    output treq_tready_o,
    input  treq_tlast_in,
    input  treq_tdata_in,
    input  treq_tkeep_in,
    input  treq_tuser_in,
    input  tresp_tready_in,
    output tresp_tvalid_o,
    output tresp_tlast_o,
    output tresp_tdata_o,
    output tresp_tkeep_o,
    output tresp_tuser_o
  );

  modport master (
    output treq_tvalid_in,
    input  treq_tready_o,
    output treq_tlast_in,
    output treq_tdata_in,
    output treq_tkeep_in,
    output treq_tuser_in,
    output tresp_tready_in,
    input  tresp_tvalid_o,
    input  tresp_tlast_o,
    input  tresp_tdata_o,
    input  tresp_tkeep_o,
    input  tresp_tuser_o
  );
endinterface

// File: rtl/db_resp_queue.sv
// Doorbell responder: watches every inbound request beat, answers each doorbell
// header with the ready status of the addressed endpoint, and queues responses
// so a stalled response sink never loses doorbells (until the queue overflows).
module db_resp_queue #(
  parameter int unsigned NUM_ED         = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [15:0] READY_INFO     = 16'h0100,
  parameter logic [15:0] NOT_READY_INFO = 16'h01FF,
  parameter logic [1:0]  RESP_PRIO      = 2'h1,
  parameter bit          USE_REQ_SRCID  = 1'b1,
  localparam int unsigned AW            = $clog2(FIFO_DEPTH)
) (
  input  logic              log_clk,
  input  logic              log_rst,
  input  logic [15:0]       src_id,
  input  logic [15:0]       des_id,
  input  logic [NUM_ED-1:0] ed_ready_in,
  db_resp_queue_if.slave    axis,
  output logic [AW:0]       pending_o,
  output logic [15:0]       drop_cnt_o
);

  localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0]  tid;
    logic [15:0] info;
    logic [15:0] dest;
  } entry_t;

  // Packet framing and header capture
  logic   first_beat_q, first_beat_d;
  logic   cap_vld_q, cap_vld_d;
  entry_t cap_q, cap_d;

  // Response queue
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  // Output register
  logic        out_vld_q, out_vld_d;
  logic [63:0] out_tdata_q, out_tdata_d;
  logic [31:0] out_tuser_q, out_tuser_d;

  logic   hdr_db;
  logic   ready_hit;
  logic   [7:0] idx;
  entry_t hdr_entry;
  logic   push, pop, drop;
  entry_t head;

  // Header decode: a doorbell is an FTYPE 4'hA beat seen while expecting a header.
  always_comb begin
    hdr_db    = axis.treq_tvalid_in && first_beat_q && (axis.treq_tdata_in[55:52] == 4'hA);
    idx       = axis.treq_tdata_in[23:16];
    ready_hit = 1'b0;
    // Loop compare avoids indexing ed_ready_in out of range.
    for (int unsigned i = 0; i < NUM_ED; i++) begin
      if (idx == 8'(i)) ready_hit = ed_ready_in[i];
    end
    hdr_entry.tid  = axis.treq_tdata_in[63:56];
    hdr_entry.info = ready_hit ? READY_INFO : NOT_READY_INFO;
    hdr_entry.dest = USE_REQ_SRCID ? axis.treq_tuser_in[31:16] : des_id;
  end

  // Framing and capture next state.
  always_comb begin
    first_beat_d = first_beat_q;
    if (axis.treq_tvalid_in) first_beat_d = axis.treq_tlast_in;
    cap_vld_d = hdr_db;
    cap_d     = hdr_db ? hdr_entry : cap_q;
  end

  // Queue control: a full queue still accepts a push when the head leaves this cycle.
  always_comb begin
    head = mem_q[rd_ptr_q];
    pop  = (count_q != '0) && (!out_vld_q || axis.tresp_tready_in);
    push = cap_vld_q && ((count_q != FullCnt) || pop);
    drop = cap_vld_q && !push;
  end

  // Queue next state.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = cap_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Output register: load from head, clear after a transfer with nothing behind it.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_tdata_d = out_tdata_q;
    out_tuser_d = out_tuser_q;
    if (pop) begin
      out_vld_d   = 1'b1;
      out_tdata_d = {head.tid, 4'hA, 4'h0, 1'b0, RESP_PRIO, 1'b0, 12'h000, head.info, 16'h0000};
      out_tuser_d = {src_id, head.dest};
    end else if (out_vld_q && axis.tresp_tready_in) begin
      out_vld_d   = 1'b0;
      out_tdata_d = '0;
      out_tuser_d = '0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      first_beat_q <= 1'b1;
      cap_vld_q    <= 1'b0;
      cap_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      out_vld_q    <= 1'b0;
      out_tdata_q  <= '0;
      out_tuser_q  <= '0;
    end else begin
      first_beat_q <= first_beat_d;
      cap_vld_q    <= cap_vld_d;
      cap_q        <= cap_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      out_vld_q    <= out_vld_d;
      out_tdata_q  <= out_tdata_d;
      out_tuser_q  <= out_tuser_d;
    end
  end

  // Queue storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge log_clk) begin
    mem_q <= mem_d;
  end

  assign axis.treq_tready_o = 1'b1;
  assign axis.tresp_tvalid_o = out_vld_q;
  assign axis.tresp_tlast_o  = out_vld_q;
  assign axis.tresp_tkeep_o  = {8{out_vld_q}};
  assign axis.tresp_tdata_o  = out_tdata_q;
  assign axis.tresp_tuser_o  = out_tuser_q;
  assign pending_o           = count_q;
  assign drop_cnt_o          = drop_cnt_q;

  // Request fields the responder never looks at.
  logic unused_bits;
  assign unused_bits = ^{axis.treq_tkeep_in, axis.treq_tdata_in[51:24],
                         axis.treq_tdata_in[15:0], axis.treq_tuser_in[15:0], des_id};

endmodule

// File: tb/tb_db_resp_queue.sv
// Directed bench for db_resp_queue with default parameters (NUM_ED=2, FIFO_DEPTH=4).
module tb_db_resp_queue;

  logic        log_clk = 1'b0;
  logic        log_rst;
  logic [15:0] src_id;
  logic [15:0] des_id;
  logic [1:0]  ed_ready_in;
  logic [2:0]  pending_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int passes = 0;

  db_resp_queue_if bus ();

  db_resp_queue dut (
    .log_clk     (log_clk),
    .log_rst     (log_rst),
    .src_id      (src_id),
    .des_id      (des_id),
    .ed_ready_in (ed_ready_in),
    .axis        (bus),
    .pending_o   (pending_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 log_clk = ~log_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance n cycles; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge log_clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] data, input logic [31:0] user, input logic last);
    bus.treq_tvalid_in = 1'b1;
    bus.treq_tdata_in  = data;
    bus.treq_tuser_in  = user;
    bus.treq_tlast_in  = last;
    step(1);
    bus.treq_tvalid_in = 1'b0;
    bus.treq_tdata_in  = '0;
    bus.treq_tuser_in  = '0;
    bus.treq_tlast_in  = 1'b0;
  endtask

  function automatic logic [63:0] db(input logic [7:0] tid, input logic [15:0] info);
    return {tid, 4'hA, 20'h00000, info, 16'h0000};
  endfunction

  // Expected response header: prio 1 lands at bits 46:45.
  function automatic logic [63:0] rsp(input logic [7:0] tid, input logic [15:0] info);
    return {tid, 4'hA, 4'h0, 1'b0, 2'b01, 1'b0, 12'h000, info, 16'h0000};
  endfunction

  initial begin
    log_rst = 1'b1;
    src_id = 16'h5A5A;
    des_id = 16'hD00D;
    ed_ready_in = 2'b10;
    bus.treq_tvalid_in = 1'b0;
    bus.treq_tlast_in = 1'b0;
    bus.treq_tdata_in = '0;
    bus.treq_tkeep_in = 8'hFF;
    bus.treq_tuser_in = '0;
    bus.tresp_tready_in = 1'b1;
    step(3);
    log_rst = 1'b0;
    step(1);

    // Reset state
    check("rst_tvalid", 64'(bus.tresp_tvalid_o), 64'd0);
    check("rst_tdata", bus.tresp_tdata_o, 64'd0);
    check("rst_pending", 64'(pending_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    check("treq_tready", 64'(bus.treq_tready_o), 64'd1);

    // Ready endpoint, latency of 3 cycles
    beat(db(8'h3C, 16'h0001), 32'h00AB_0001, 1'b1);
    check("lat_n1", 64'(bus.tresp_tvalid_o), 64'd0);
    step(1);
    check("lat_n2", 64'(bus.tresp_tvalid_o), 64'd0);
    step(1);
    check("lat_n3", 64'(bus.tresp_tvalid_o), 64'd1);
    check("rdy_tdata", bus.tresp_tdata_o, 64'h3CA0_2000_0100_0000);
    check("rdy_tuser", 64'(bus.tresp_tuser_o), 64'h5A5A_00AB);
    check("rdy_tlast", 64'(bus.tresp_tlast_o), 64'd1);
    check("rdy_tkeep", 64'(bus.tresp_tkeep_o), 64'hFF);
    step(1);
    check("idle_tvalid", 64'(bus.tresp_tvalid_o), 64'd0);
    check("idle_tdata", bus.tresp_tdata_o, 64'd0);
    check("idle_tuser", 64'(bus.tresp_tuser_o), 64'd0);
    check("idle_tkeep", 64'(bus.tresp_tkeep_o), 64'd0);
    check("idle_tlast", 64'(bus.tresp_tlast_o), 64'd0);

    // Not-ready and out-of-range index, back to back
    beat(db(8'h11, 16'h0000), 32'h0022_0000, 1'b1);
    beat(db(8'h12, 16'h0007), 32'h0033_0007, 1'b1);
    step(1);
    check("nrdy_tdata", bus.tresp_tdata_o, rsp(8'h11, 16'h01FF));
    check("nrdy_tuser", 64'(bus.tresp_tuser_o), 64'h5A5A_0022);
    step(1);
    check("oor_tdata", bus.tresp_tdata_o, rsp(8'h12, 16'h01FF));
    step(1);
    check("oor_idle", 64'(bus.tresp_tvalid_o), 64'd0);

    // Backpressure: three doorbells while the sink is stalled
    bus.tresp_tready_in = 1'b0;
    beat(db(8'h21, 16'h0001), 32'h0101_0001, 1'b1);
    beat(db(8'h22, 16'h0001), 32'h0102_0001, 1'b1);
    beat(db(8'h23, 16'h0001), 32'h0103_0001, 1'b1);
    step(2);
    check("bp_pending", 64'(pending_o), 64'd2);
    check("bp_tvalid", 64'(bus.tresp_tvalid_o), 64'd1);
    check("bp_tdata", bus.tresp_tdata_o, rsp(8'h21, 16'h0100));
    step(2);
    check("bp_hold_tdata", bus.tresp_tdata_o, rsp(8'h21, 16'h0100));
    check("bp_hold_tuser", 64'(bus.tresp_tuser_o), 64'h5A5A_0101);
    bus.tresp_tready_in = 1'b1;
    step(1);
    check("bp_r2", bus.tresp_tdata_o, rsp(8'h22, 16'h0100));
    step(1);
    check("bp_r3", bus.tresp_tdata_o, rsp(8'h23, 16'h0100));
    step(1);
    check("bp_done", 64'(bus.tresp_tvalid_o), 64'd0);
    check("bp_pending0", 64'(pending_o), 64'd0);

    // Overflow: 7 doorbells into 1 output register + 4 queue slots
    bus.tresp_tready_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      beat(db(8'h31 + 8'(k), 16'(k % 2 == 0)), 32'h0200_0000, 1'b1);
    end
    step(1);
    check("ovf_pending", 64'(pending_o), 64'd4);
    check("ovf_drop", 64'(drop_cnt_o), 64'd2);
    check("ovf_out", bus.tresp_tdata_o, rsp(8'h31, 16'h0100));
    bus.tresp_tready_in = 1'b1;
    step(1);
    check("ovf_q0", bus.tresp_tdata_o, rsp(8'h32, 16'h01FF));
    step(1);
    check("ovf_q1", bus.tresp_tdata_o, rsp(8'h33, 16'h0100));
    step(1);
    check("ovf_q2", bus.tresp_tdata_o, rsp(8'h34, 16'h01FF));
    step(1);
    check("ovf_q3", bus.tresp_tdata_o, rsp(8'h35, 16'h0100));
    step(1);
    check("ovf_idle", 64'(bus.tresp_tvalid_o), 64'd0);

    // Filtering: NWRITE whose payload looks like a doorbell, then a 2-beat doorbell
    bus.tresp_tready_in = 1'b0;
    beat(64'h0050_0000_0000_0000, 32'h0300_0000, 1'b0);
    beat(db(8'h77, 16'h0001), 32'h0300_0000, 1'b0);
    beat(64'h1234_5678_9ABC_DEF0, 32'h0300_0000, 1'b1);
    beat(db(8'h78, 16'h0001), 32'h0304_0001, 1'b0);
    beat(db(8'h79, 16'h0001), 32'h0304_0001, 1'b1);
    step(3);
    check("flt_tvalid", 64'(bus.tresp_tvalid_o), 64'd1);
    check("flt_tdata", bus.tresp_tdata_o, rsp(8'h78, 16'h0100));
    check("flt_pending", 64'(pending_o), 64'd0);
    bus.tresp_tready_in = 1'b1;
    step(1);
    check("flt_idle", 64'(bus.tresp_tvalid_o), 64'd0);

    // Reset mid-operation, with first_beat cleared by an open packet
    bus.tresp_tready_in = 1'b0;
    beat(db(8'h41, 16'h0001), 32'h0400_0001, 1'b1);
    beat(db(8'h42, 16'h0001), 32'h0400_0001, 1'b1);
    beat(db(8'h43, 16'h0001), 32'h0400_0001, 1'b1);
    beat(64'h0050_0000_0000_0000, 32'h0400_0000, 1'b0);
    check("pre_rst_pending", 64'(pending_o), 64'd2);
    check("pre_rst_tvalid", 64'(bus.tresp_tvalid_o), 64'd1);
    check("pre_rst_drop", 64'(drop_cnt_o), 64'd2);
    log_rst = 1'b1;
    step(1);
    log_rst = 1'b0;
    check("mid_rst_tvalid", 64'(bus.tresp_tvalid_o), 64'd0);
    check("mid_rst_tdata", bus.tresp_tdata_o, 64'd0);
    check("mid_rst_tuser", 64'(bus.tresp_tuser_o), 64'd0);
    check("mid_rst_pending", 64'(pending_o), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
    bus.tresp_tready_in = 1'b1;
    beat(db(8'h5E, 16'h0001), 32'h0500_0001, 1'b1);
    step(2);
    check("post_rst_tvalid", 64'(bus.tresp_tvalid_o), 64'd1);
    check("post_rst_tdata", bus.tresp_tdata_o, rsp(8'h5E, 16'h0100));
    check("post_rst_tuser", 64'(bus.tresp_tuser_o), 64'h5A5A_0500);
    step(1);
    check("post_rst_idle", 64'(bus.tresp_tvalid_o), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/db_resp_queue.md
Name: db_resp_queue

Overview:
Parametrised doorbell responder for the RapidIO logical layer. It accepts every inbound request beat on the treq AXI-Stream and detects doorbell (FTYPE 4'hA) headers. For each doorbell it reports the ready status of the endpoint addressed by the doorbell info field. Responses are queued in a FIFO and driven on the tresp stream with full valid/ready backpressure, so consecutive doorbells are not lost while tresp is stalled.

Parameters:
NUM_ED, 2, number of endpoint ready flags (1..256).
FIFO_DEPTH, 4, pending-response queue depth; power of 2, minimum 2.
READY_INFO, 16'h0100, info field returned when the addressed endpoint is ready.
NOT_READY_INFO, 16'h01FF, info field returned when the endpoint is not ready or the index is out of range.
RESP_PRIO, 2'h1, prio field of generated doorbells.
USE_REQ_SRCID, 1, 1: response destination is the requester's source ID; 0: response destination is the des_id port.

Ports:
log_clk  in  1  logic clock; everything is clocked on the rising edge.
log_rst  in  1  synchronous reset, active-high.
src_id  in  16  own device ID, placed in tresp_tuser_o[31:16].
des_id  in  16  static destination, used when USE_REQ_SRCID=0.
ed_ready_in  in  NUM_ED  per-endpoint ready flags.
treq_tvalid_in  in  1  request beat valid.
treq_tready_o  out  1  held at 1; the block never stalls requests.
treq_tlast_in  in  1  last beat of the packet.
treq_tdata_in  in  64  request beat.
treq_tkeep_in  in  8  unused.
treq_tuser_in  in  32  [31:16] requester source ID, [15:0] destination.
tresp_tready_in  in  1  response sink ready.
tresp_tvalid_o  out  1  response valid.
tresp_tlast_o  out  1  1 whenever tvalid is 1 (single-beat packets).
tresp_tdata_o  out  64  response header.
tresp_tkeep_o  out  8  8'hFF when valid, else 0.
tresp_tuser_o  out  32  {src_id, destination}.
pending_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy (excludes the output register).
drop_cnt_o  out  16  doorbells dropped because the FIFO was full; saturates at 16'hFFFF.

Behaviour:
- Reset: first_beat=1, FIFO empty, pending_o=0, drop_cnt_o=0. All tresp_* outputs are 0.
- Beat acceptance: a beat is accepted when treq_tvalid_in=1.
- first_beat tracking: first_beat is set after an accepted beat with tlast=1 and cleared after an accepted beat with tlast=0.
- Header detection: only an accepted beat while first_beat=1 is a header. A header with tdata[55:52]==4'hA is a doorbell; any other FTYPE is ignored. Later beats of a multi-beat doorbell are ignored.
- Doorbell capture fields: tid=tdata[63:56], info=tdata[31:16], req_src=treq_tuser_in[31:16].
- Endpoint index: idx = info[7:0].
- Response info: READY_INFO if idx<NUM_ED and ed_ready_in[idx]=1 in the header cycle; otherwise NOT_READY_INFO. ed_ready_in is sampled only in the header cycle.
- Response destination: req_src if USE_REQ_SRCID=1, otherwise des_id sampled in the header cycle.
- Capture register: the doorbell header is registered at cycle N. At the end of cycle N+1 the entry {tid, resp_info, dest} is pushed into the FIFO.
- Full FIFO: if the FIFO is full at push time and no pop occurs in the same cycle, the entry is dropped and drop_cnt_o increments by 1, saturating.
- Push and pop in the same cycle on a full FIFO: the push succeeds and occupancy is unchanged.
- Output register load: the register loads from the FIFO head when the FIFO is not empty and either tresp_tvalid_o=0 or tresp_tready_in=1.
- Empty-queue latency: tresp_tvalid_o=1 in cycle N+3 for a header accepted in cycle N.
- Back-to-back throughput: one response per cycle while tresp_tready_in=1.
- Backpressure: while tresp_tvalid_o=1 and tresp_tready_in=0, every tresp_* output holds stable.
- Idle output: after a transfer with no FIFO entry available, tvalid, tlast, tdata, tkeep and tuser all return to 0.
- Response tdata layout, MSB first: tid[7:0], 4'hA, 4'b0, 1'b0, RESP_PRIO, 1'b0, 12'b0, resp_info[15:0], 16'h0.
- Response tuser: tresp_tuser_o = {src_id, dest}.
- Reset mid-operation: any queued or presented response is discarded and tvalid drops on the cycle after reset. The first beat accepted after reset is treated as a header.
- Ordering: responses are issued in the order their requests arrived.

Test Plan:
- Ready endpoint: NUM_ED=2, ed_ready_in=2'b10. Send a single-beat doorbell with tid=8'h3C, info=16'h0001, tuser=32'h00AB_0001. Required: tvalid rises 3 cycles later, tdata=64'h3CA0_2000_0100_0000, tuser={src_id,16'h00AB}, tlast=1, tkeep=8'hFF.
- Not-ready and out-of-range index: ed_ready_in=2'b10. Doorbells with info=16'h0000 and info=16'h0007 both return info 16'h01FF.
- Backpressure: tresp_tready_in=0 while 3 doorbells arrive. Required: pending_o=2 and the output is held stable. Release ready: 3 responses in consecutive cycles, tid order preserved.
- Overflow: FIFO_DEPTH=4, ready=0, 7 doorbells. Required: 1 in the output register, 4 queued, drop_cnt_o=2, no corruption of the queued entries.
- Filtering: NWRITE (FTYPE 5) 3-beat packet whose beat 2 carries 4'hA in bits [55:52], then a 2-beat doorbell. Required: exactly one response.
- Reset mid-operation: assert log_rst for 1 cycle while tvalid=1 with 2 entries pending. Required: outputs 0 on the next cycle, pending_o=0, drop_cnt_o=0, and a subsequent doorbell is answered normally.
